// File: rtl/acc_issue_queue.sv
// Commit-gated issue queue feeding the vector accelerator: entries are held until committed, then dispatched under an in-flight cap.
// Optional stall counter enabled by defining ACC_ISSUE_QUEUE_STATS_EN.
module acc_issue_queue #(
  parameter int DEPTH           = 4,
  parameter int DATA_W          = 160,
  parameter int MAX_OUTSTANDING = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              enq_valid_i,
  output logic              enq_ready_o,
  input  logic [DATA_W-1:0] enq_data_i,
  input  logic              commit_i,
  output logic              acc_req_valid_o,
  input  logic              acc_req_ready_i,
  output logic [DATA_W-1:0] acc_req_data_o,
  input  logic              acc_resp_valid_i,
  output logic [3:0]        outstanding_o,
  output logic              empty_o,
  output logic              commit_err_o,
  output logic [31:0]       stall_cycles_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       head, cmt, tail;
  logic [AW:0]       cmt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [3:0]        outstanding;
  logic              full, enq_fire, cmt_ok, disp, rsp_ok, err_set;

  assign full            = (tail[AW-1:0] == head[AW-1:0]) && (tail[AW] != head[AW]);
  assign enq_ready_o     = !full && !flush_i;
  assign enq_fire        = enq_valid_i && enq_ready_o;
  // Compared against the pre-enqueue tail, so a same-cycle enqueue is never committed.
  assign cmt_ok          = commit_i && (cmt != tail);
  assign cmt_nxt         = cmt + {{AW{1'b0}}, cmt_ok};
  assign acc_req_valid_o = (head != cmt) && (outstanding < MAX_O);
  assign disp            = acc_req_valid_o && acc_req_ready_i;
  assign rsp_ok          = acc_resp_valid_i && (outstanding != 4'd0);
  assign err_set         = (commit_i && (cmt == tail)) || (acc_resp_valid_i && (outstanding == 4'd0));
  assign acc_req_data_o  = mem[head[AW-1:0]];
  assign outstanding_o   = outstanding;
  assign empty_o         = (tail == head);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head         <= '0;
      cmt          <= '0;
      tail         <= '0;
      outstanding  <= '0;
      commit_err_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (enq_fire) mem[tail[AW-1:0]] <= enq_data_i;
      if (disp) head <= head + {{AW{1'b0}}, 1'b1};
      cmt <= cmt_nxt;
      // Flush drops everything past the (updated) commit point.
      if (flush_i)       tail <= cmt_nxt;
      else if (enq_fire) tail <= tail + {{AW{1'b0}}, 1'b1};
      case ({disp, rsp_ok})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
      if (err_set) commit_err_o <= 1'b1;
    end
  end

`ifdef ACC_ISSUE_QUEUE_STATS_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i)
      stall_cnt <= '0;
    else if ((head != cmt) && !disp && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
  assign stall_cycles_o = stall_cnt;
`else
  assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_acc_issue_queue.sv
// Randomized + directed bench for acc_issue_queue against a queue-based reference model.
module tb_acc_issue_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 160;
  localparam int MAXO  = 7;

  logic          clk_i = 1'b0;
  logic          rst_i, flush_i, enq_valid_i, commit_i, acc_req_ready_i, acc_resp_valid_i;
  logic [DW-1:0] enq_data_i, acc_req_data_o;
  logic          enq_ready_o, acc_req_valid_o, empty_o, commit_err_o;
  logic [3:0]    outstanding_o;
  logic [31:0]   stall_cycles_o;

  acc_issue_queue #(.DEPTH(DEPTH), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o), .enq_data_i(enq_data_i),
    .commit_i(commit_i), .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
    .acc_req_data_o(acc_req_data_o), .acc_resp_valid_i(acc_resp_valid_i),
    .outstanding_o(outstanding_o), .empty_o(empty_o), .commit_err_o(commit_err_o),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: committed and uncommitted entries as plain queues.
  logic [DW-1:0] q_cmt[$];
  logic [DW-1:0] q_unc[$];
  int            m_out;
  bit            m_err;
  longint        m_stall;
  logic [DW-1:0] last_data;
  int            pass_cnt = 0;
  int            total    = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  function automatic bit m_valid();
    return (q_cmt.size() > 0) && (m_out < MAXO);
  endfunction

  task automatic compare(input bit fl);
    bit full;
    full = (q_cmt.size() + q_unc.size()) == DEPTH;
    chk("enq_ready", enq_ready_o, !full && !fl);
    chk("req_valid", acc_req_valid_o, m_valid());
    if (m_valid()) chk("req_data", acc_req_data_o, q_cmt[0]);
    chk("outstanding", outstanding_o, m_out);
    chk("empty", empty_o, (q_cmt.size() + q_unc.size()) == 0);
    chk("commit_err", commit_err_o, m_err);
    chk("stall_cycles", stall_cycles_o, m_stall[31:0]);
  endtask

  task automatic step(input bit en, input bit cm, input bit fl, input bit rdy, input bit rsp);
    bit full, fire, disp;
    @(negedge clk_i);
    last_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
    enq_valid_i = en; enq_data_i = last_data; commit_i = cm; flush_i = fl;
    acc_req_ready_i = rdy; acc_resp_valid_i = rsp;
    #1;
    compare(fl);
    full = (q_cmt.size() + q_unc.size()) == DEPTH;
    fire = en && !full && !fl;
    disp = m_valid() && rdy;
`ifdef ACC_ISSUE_QUEUE_STATS_EN
    if (q_cmt.size() > 0 && !disp && m_stall < 64'hFFFF_FFFF) m_stall++;
`endif
    if (disp) void'(q_cmt.pop_front());
    if (cm) begin
      if (q_unc.size() > 0) q_cmt.push_back(q_unc.pop_front());
      else m_err = 1;
    end
    if (fl) q_unc.delete();
    if (fire) q_unc.push_back(last_data);
    if (rsp) begin
      if (m_out == 0) m_err = 1;
      else m_out--;
    end
    if (disp) m_out++;
    @(posedge clk_i);
    #1;
    enq_valid_i = 0; commit_i = 0; flush_i = 0; acc_req_ready_i = 0; acc_resp_valid_i = 0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1; enq_valid_i = 0; commit_i = 0; flush_i = 0; acc_req_ready_i = 0; acc_resp_valid_i = 0;
    @(posedge clk_i);
    #1 rst_i = 0;
    q_cmt.delete(); q_unc.delete(); m_out = 0; m_err = 0; m_stall = 0;
    #1;
  endtask

  logic [DW-1:0] a_data;

  initial begin
    rst_i = 1; flush_i = 0; enq_valid_i = 0; commit_i = 0;
    acc_req_ready_i = 0; acc_resp_valid_i = 0; enq_data_i = '0;
    @(posedge clk_i);
    do_reset();
    chk("rst_enq_ready", enq_ready_o, 1);
    chk("rst_valid", acc_req_valid_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_err", commit_err_o, 0);
    chk("rst_stall", stall_cycles_o, 0);
    chk("rst_data", acc_req_data_o, 0);
    chk("rst_out", outstanding_o, 0);

    // Uncommitted entries are never presented.
    step(1, 0, 0, 0, 0); a_data = last_data;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      chk("no_commit_valid", acc_req_valid_o, 0);
    end
    step(0, 1, 0, 0, 0);
    chk("commit_valid", acc_req_valid_o, 1);
    chk("commit_data_a", acc_req_data_o, a_data);
    step(0, 1, 0, 1, 0);
    chk("out_after_a", outstanding_o, 1);
    step(0, 0, 0, 1, 1);
    chk("disp_rsp_same", outstanding_o, 1);
    step(0, 0, 0, 0, 1);

    // Fill, blocked enqueue, then stream out.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    chk("full_ready", enq_ready_o, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("fill_out4", outstanding_o, 4);
    chk("fill_empty", empty_o, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

    // Outstanding cap.
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 1, 0);
      step(0, 1, 0, 1, 0);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("cap_out7", outstanding_o, 7);
    chk("cap_held", acc_req_valid_o, 0);
    step(0, 0, 0, 1, 1);
    chk("cap_release", acc_req_valid_o, 1);
    chk("cap_out6", outstanding_o, 6);
    step(0, 0, 0, 1, 0);
    chk("cap_out7b", outstanding_o, 7);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1);

    // Flush together with the third commit keeps three entries.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("flush_ready", enq_ready_o, 1);
    chk("flush_empty", empty_o, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    chk("flush_drained", acc_req_valid_o, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("flush_out4", outstanding_o, 4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

    // Error flag.
    step(0, 1, 0, 0, 0);
    chk("err_commit", commit_err_o, 1);
    step(0, 0, 0, 0, 0);
    chk("err_sticky", commit_err_o, 1);
    chk("err_empty", empty_o, 1);
    do_reset();
    step(0, 0, 0, 0, 1);
    chk("err_rsp", commit_err_o, 1);
    chk("err_rsp_out", outstanding_o, 0);
    do_reset();

    // Stall counter.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
`ifdef ACC_ISSUE_QUEUE_STATS_EN
    chk("stall10", stall_cycles_o, 10);
`else
    chk("stall_off", stall_cycles_o, 0);
`endif
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 4);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
